fifo_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one first-word fall-through FIFO input port among NUM_REQ

---
 rtl/pifo_arb_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 26 ++
 rtl/fifo_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pifo_arb_pkg.sv
// rtl/pifo_arb_pkg.sv - shared FSM state type and width helpers for the FIFO round-robin arbiter
package pifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int burst_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational first-valid search starting at the round-robin pointer
module rr_priority_picker
    import pifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     rr_ptr_i,
    output logic               found_o,
    output logic [IDW-1:0]     index_o
);

    // Scan from the farthest offset down so the nearest valid index overwrites last.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_i[(int'(rr_ptr_i) + i) % NUM_REQ]) begin
                found_o = 1'b1;
                index_o = IDW'((int'(rr_ptr_i) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin burst arbiter feeding a FIFO input; ARB_STATS_EN adds per-requester word counters
module fifo_rr_arbiter
    import pifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              ia__req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   ia__req_data,
    output logic [NUM_REQ-1:0]              oa__req_ready,
    output logic                            o__data_out_valid,
    output logic [DATA_WIDTH-1:0]           o__data_out,
    input  logic                            i__data_out_ready,
    output logic                            o__grant_valid,
    output logic [id_width(NUM_REQ)-1:0]    o__grant_id,
    input  logic                            i__stats_clear,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    oa__grant_count
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int BCW = burst_width(MAX_BURST);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           in_grant;
    logic           cur_valid;
    logic           xfer;
    logic           last_word;
    logic [IDW-1:0] next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .valid_i  (ia__req_valid),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .index_o  (pick_idx)
    );

    assign in_grant  = (state_q == ARB_GRANT);
    assign cur_valid = ia__req_valid[grant_id_q];
    assign xfer      = in_grant & cur_valid & i__data_out_ready;
    assign last_word = (burst_cnt_q == BCW'(MAX_BURST - 1));
    assign next_ptr  = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d     = ARB_GRANT;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                // A dropped valid releases even while the FIFO is stalled.
                if (!cur_valid || (xfer && last_word)) begin
                    state_d     = ARB_IDLE;
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        oa__req_ready     = '0;
        o__data_out_valid = in_grant & cur_valid;
        o__data_out       = '0;
        o__grant_valid    = in_grant;
        o__grant_id       = '0;
        if (in_grant) begin
            oa__req_ready[grant_id_q] = i__data_out_ready;
            o__data_out               = ia__req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
            o__grant_id               = grant_id_q;
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

    // Clear takes priority over a same-cycle transfer; counters stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (i__stats_clear) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (xfer && (cnt_q[grant_id_q] != {CNT_WIDTH{1'b1}})) begin
            cnt_q[grant_id_q] <= cnt_q[grant_id_q] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign oa__grant_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end
`else
    logic unused_stats_clear;
    assign unused_stats_clear = i__stats_clear;
    assign oa__grant_count    = '0;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed bench with reference model for fifo_rr_arbiter (ARB_STATS_EN optional)
module tb_fifo_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int MB  = 4;
    localparam int CW  = 2;
    localparam int IDW = 2;
`ifdef ARB_STATS_EN
    localparam int STATS   = 1;
    localparam int EXP_SAT = 3;
`else
    localparam int STATS   = 0;
    localparam int EXP_SAT = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      valid;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              ready;
    logic              grant_valid;
    logic [IDW-1:0]    grant_id;
    logic              clear;
    logic [N*CW-1:0]   counts;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    fifo_rr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ia__req_valid     (valid),
        .ia__req_data      (data),
        .oa__req_ready     (req_ready),
        .o__data_out_valid (out_valid),
        .o__data_out       (out_data),
        .i__data_out_ready (ready),
        .o__grant_valid    (grant_valid),
        .o__grant_id       (grant_id),
        .i__stats_clear    (clear),
        .oa__grant_count   (counts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: who owns the port, how many words it has moved, where the search starts next.
    bit m_busy  = 1'b0;
    int m_gid   = 0;
    int m_words = 0;
    int m_ptr   = 0;
    int m_cnt [N] = '{default: 0};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  <= 1'b0;
            m_gid   <= 0;
            m_words <= 0;
            m_ptr   <= 0;
            for (int j = 0; j < N; j++) m_cnt[j] <= 0;
        end else begin
            automatic bit xf   = m_busy && valid[m_gid] && ready;
            automatic bit done = 1'b0;
            if (STATS != 0) begin
                if (clear) for (int j = 0; j < N; j++) m_cnt[j] <= 0;
                else if (xf && m_cnt[m_gid] < (1 << CW) - 1) m_cnt[m_gid] <= m_cnt[m_gid] + 1;
            end
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (!done && valid[(m_ptr + k) % N]) begin
                        done = 1'b1;
                        m_busy  <= 1'b1;
                        m_gid   <= (m_ptr + k) % N;
                        m_words <= 0;
                    end
                end
            end else if (!valid[m_gid] || (xf && m_words + 1 == MB)) begin
                m_busy  <= 1'b0;
                m_words <= 0;
                m_ptr   <= (m_gid + 1) % N;
            end else if (xf) begin
                m_words <= m_words + 1;
            end
        end
    end

    always @(negedge clk) begin
        automatic logic [N*CW-1:0] exp_cnt = '0;
        automatic logic [N-1:0]    exp_rdy = '0;
        if (m_busy && ready) exp_rdy[m_gid] = 1'b1;
        for (int j = 0; j < N; j++) exp_cnt[j*CW +: CW] = CW'(m_cnt[j]);
        chk("m_out_valid", out_valid, m_busy && valid[m_gid]);
        chk("m_out_data", out_data, m_busy ? data[m_gid*DW +: DW] : '0);
        chk("m_req_ready", req_ready, exp_rdy);
        chk("m_grant_valid", grant_valid, m_busy);
        chk("m_grant_id", grant_id, m_busy ? m_gid : 0);
        chk("m_counts", counts, exp_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int j = 0; j < N; j++) data[j*DW +: DW] = DW'((j << 12) | (cyc & 12'hfff));
    endtask

    // Per cycle: granted id if a word moves this cycle, 9 otherwise.
    task automatic chk_trace(input string nm, input int e[$]);
        foreach (e[i]) begin
            #1;
            chk(nm, (out_valid && ready) ? 64'(grant_id) : 64'd9, 64'(e[i]));
            tick();
        end
    endtask

    initial begin
        int q[$];
        reset = 1'b0;
        valid = '1;
        ready = 1'b1;
        clear = 1'b0;
        data  = '0;
        repeat (3) tick();

        // Held in reset with every requester valid.
        #1;
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        reset = 1'b1;
        #1;
        chk("bubble_grant_valid", grant_valid, 0);
        tick();
        #1;
        chk("first_grant_valid", grant_valid, 1);
        chk("first_grant_id", grant_id, 0);

        q = {0,0,0,0,9,1,1,1,1,9,2,2,2,2,9,3,3,3,3,9,0};
        chk_trace("all_valid_rotation", q);

        valid = 4'b0100;
        q = {9,9,2,2,2,2,9,2,2};
        chk_trace("lone_req2", q);

        valid = 4'b0010;
        q = {9,9};
        chk_trace("to_req1", q);
        ready = 1'b0;
        repeat (10) begin
            #1;
            chk("stall_grant_valid", grant_valid, 1);
            chk("stall_grant_id", grant_id, 1);
            chk("stall_req_ready", req_ready, 0);
            tick();
        end
        ready = 1'b1;
        q = {1,1,1,1,9};
        chk_trace("stall_resume", q);

        valid = 4'b1000;
        q = {9,9,3,3};
        chk_trace("req3_two_words", q);
        valid = 4'b0011;
        q = {9,9,0,0,0,0,9,1,1};
        chk_trace("req3_drop_wrap", q);

        // Asynchronous reset in the middle of a burst.
        reset = 1'b0;
        #1;
        chk("midrst_grant_valid", grant_valid, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        valid = 4'b0001;
        tick();
        reset = 1'b1;
        q = {9,0,0,0,0,9,0};
        chk_trace("five_words_req0", q);
        chk("count_sat", counts[CW-1:0], EXP_SAT);
        chk("count_others", counts[N*CW-1:CW], 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("count_cleared", counts[CW-1:0], 0);
        tick();
        #1;
        chk("count_after_clear", counts[CW-1:0], (STATS != 0) ? 1 : 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
